// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max-pooling on a raster-ordered, hcount/vcount-tagged stream.
// Horizontal pair maxima of even rows wait in a half-row buffer for the matching odd-row pair.
module relu_maxpool_2x2 #(
    parameter int IN_WIDTH  = 26,
    parameter int IN_HEIGHT = 26
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               data_valid_in,
    input  logic signed [20:0] pixel_data_in,
    input  logic        [4:0]  hcount_in,
    input  logic        [4:0]  vcount_in,
    output logic               data_valid_out,
    output logic signed [20:0] pixel_data_out,
    output logic        [4:0]  hcount_out,
    output logic        [4:0]  vcount_out
);

    localparam int         NPAIR = IN_WIDTH / 2;
    localparam logic [5:0] W_LIM = 6'(IN_WIDTH);
    localparam logic [5:0] H_LIM = 6'(IN_HEIGHT);

    logic signed [20:0] pair_reg_q, pair_reg_d;
    logic        [3:0]  pair_col_q, pair_col_d;
    logic               pair_valid_q, pair_valid_d;
    logic signed [20:0] rowbuf_q [NPAIR];
    logic signed [20:0] rowbuf_d [NPAIR];
    logic [NPAIR-1:0]   rb_valid_q, rb_valid_d;
    logic               dv_q, dv_d;
    logic signed [20:0] pix_q, pix_d;
    logic        [4:0]  hout_q, hout_d;
    logic        [4:0]  vout_q, vout_d;

    logic signed [20:0] relu_val;
    logic signed [20:0] pair_max;
    logic signed [20:0] buf_val;
    logic        [3:0]  rb_idx;
    logic               in_range;

    always_comb begin
        relu_val = pixel_data_in[20] ? 21'sd0 : pixel_data_in;
        in_range = data_valid_in && ({1'b0, hcount_in} < W_LIM) && ({1'b0, vcount_in} < H_LIM);
        rb_idx   = hcount_in[4:1];
        pair_max = (pair_reg_q > relu_val) ? pair_reg_q : relu_val;
        buf_val  = rowbuf_q[rb_idx];
    end

    always_comb begin
        pair_reg_d   = pair_reg_q;
        pair_col_d   = pair_col_q;
        pair_valid_d = pair_valid_q;
        rowbuf_d     = rowbuf_q;
        rb_valid_d   = rb_valid_q;
        dv_d         = 1'b0;
        pix_d        = pix_q;
        hout_d       = hout_q;
        vout_d       = vout_q;

        if (in_range) begin
            if (!hcount_in[0]) begin
                pair_reg_d   = relu_val;
                pair_col_d   = rb_idx;
                pair_valid_d = 1'b1;
            end else begin
                // Any odd column closes the pair window, matched or not.
                pair_valid_d = 1'b0;
                if (pair_valid_q && (pair_col_q == rb_idx)) begin
                    if (!vcount_in[0]) begin
                        rowbuf_d[rb_idx]   = pair_max;
                        rb_valid_d[rb_idx] = 1'b1;
                    end else if (rb_valid_q[rb_idx]) begin
                        rb_valid_d[rb_idx] = 1'b0;
                        dv_d   = 1'b1;
                        pix_d  = (buf_val > pair_max) ? buf_val : pair_max;
                        hout_d = {1'b0, hcount_in[4:1]};
                        vout_d = {1'b0, vcount_in[4:1]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pair_reg_q   <= '0;
            pair_col_q   <= '0;
            pair_valid_q <= 1'b0;
            rb_valid_q   <= '0;
            dv_q         <= 1'b0;
            pix_q        <= '0;
            hout_q       <= '0;
            vout_q       <= '0;
        end else begin
            pair_reg_q   <= pair_reg_d;
            pair_col_q   <= pair_col_d;
            pair_valid_q <= pair_valid_d;
            rb_valid_q   <= rb_valid_d;
            dv_q         <= dv_d;
            pix_q        <= pix_d;
            hout_q       <= hout_d;
            vout_q       <= vout_d;
        end
    end

    // Buffer data needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk_in) begin
        rowbuf_q <= rowbuf_d;
    end

    assign data_valid_out = dv_q;
    assign pixel_data_out = pix_q;
    assign hcount_out     = hout_q;
    assign vcount_out     = vout_q;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Self-checking bench for relu_maxpool_2x2: a 26x26 instance and a 27x27 instance share one stimulus stream.
// Expected pooled streams come from a frame-level 2x2 max-of-ReLU model.
module tb_relu_maxpool_2x2;

    logic               clk_in;
    logic               rst_in;
    logic               data_valid_in;
    logic signed [20:0] pixel_data_in;
    logic        [4:0]  hcount_in;
    logic        [4:0]  vcount_in;

    logic               dv_a, dv_b;
    logic signed [20:0] pix_a, pix_b;
    logic        [4:0]  h_a, h_b, v_a, v_b;

    int checks   = 0;
    int failures = 0;

    int frame [32][32];
    int qa_pix[$], qa_h[$], qa_v[$];
    int qb_pix[$], qb_h[$], qb_v[$];
    int exp_pix[$], exp_h[$], exp_v[$];

    relu_maxpool_2x2 #(.IN_WIDTH(26), .IN_HEIGHT(26)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
        .pixel_data_in(pixel_data_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_out(dv_a), .pixel_data_out(pix_a), .hcount_out(h_a), .vcount_out(v_a)
    );

    relu_maxpool_2x2 #(.IN_WIDTH(27), .IN_HEIGHT(27)) dut_odd (
        .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
        .pixel_data_in(pixel_data_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_out(dv_b), .pixel_data_out(pix_b), .hcount_out(h_b), .vcount_out(v_b)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (dv_a === 1'b1) begin
            qa_pix.push_back(int'(pix_a));
            qa_h.push_back(int'(h_a));
            qa_v.push_back(int'(v_a));
        end
        if (dv_b === 1'b1) begin
            qb_pix.push_back(int'(pix_b));
            qb_h.push_back(int'(h_b));
            qb_v.push_back(int'(v_b));
        end
    end

    function automatic int rnd_pix();
        return int'($urandom_range(2097151, 0)) - 1048576;
    endfunction

    function automatic int relu(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic clear_queues();
        qa_pix.delete(); qa_h.delete(); qa_v.delete();
        qb_pix.delete(); qb_h.delete(); qb_v.delete();
    endtask

    task automatic drive_sample(input int h, input int v, input int d);
        data_valid_in = 1'b1;
        hcount_in     = 5'(h);
        vcount_in     = 5'(v);
        pixel_data_in = 21'(d);
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        data_valid_in = 1'b0;
        hcount_in     = 5'($urandom);
        vcount_in     = 5'($urandom);
        pixel_data_in = 21'($urandom);
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_rows(input int w, input int y0, input int y1, input int duty);
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < w; x++) begin
                while (int'($urandom_range(99, 0)) >= duty) drive_idle();
                drive_sample(x, y, frame[y][x]);
            end
        end
        repeat (4) drive_idle();
    endtask

    task automatic build_expected(input int w, input int h);
        exp_pix.delete(); exp_h.delete(); exp_v.delete();
        for (int y = 0; y < h / 2; y++) begin
            for (int x = 0; x < w / 2; x++) begin
                exp_pix.push_back(max2(max2(relu(frame[2*y][2*x]), relu(frame[2*y][2*x+1])),
                                       max2(relu(frame[2*y+1][2*x]), relu(frame[2*y+1][2*x+1]))));
                exp_h.push_back(x);
                exp_v.push_back(y);
            end
        end
    endtask

    task automatic compare_stream(input int which, input string name);
        int gp[$], gh[$], gv[$];
        int n;
        if (which == 0) begin gp = qa_pix; gh = qa_h; gv = qa_v; end
        else            begin gp = qb_pix; gh = qb_h; gv = qb_v; end
        checks++;
        if (gp.size() !== exp_pix.size()) begin
            failures++;
            $display("[TB] FAIL %s count: got %0d expected %0d", name, gp.size(), exp_pix.size());
        end
        n = (gp.size() < exp_pix.size()) ? gp.size() : exp_pix.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (gp[i] !== exp_pix[i] || gh[i] !== exp_h[i] || gv[i] !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL %s out[%0d]: got pix=%0d h=%0d v=%0d expected pix=%0d h=%0d v=%0d",
                         name, i, gp[i], gh[i], gv[i], exp_pix[i], exp_h[i], exp_v[i]);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                frame[y][x] = y * 26 + x;
    endtask

    task automatic fill_random();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                frame[y][x] = rnd_pix();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_valid_in = 1'b1;
            hcount_in     = 5'($urandom);
            vcount_in     = 5'($urandom);
            pixel_data_in = 21'($urandom);
            @(posedge clk_in);
            #1;
            checks++;
            if ({dv_a, pix_a, h_a, v_a} !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_hold: got dv=%0b pix=%0d h=%0d v=%0d expected all 0", dv_a, pix_a, h_a, v_a);
            end
        end
        checks++;
        if (qa_pix.size() !== 0) begin
            failures++;
            $display("[TB] FAIL reset_no_pulse: got %0d pulses expected 0", qa_pix.size());
        end
        rst_in = 1'b1;
        drive_idle();
        clear_queues();
        drive_sample(0, 0, 5);
        drive_sample(1, 0, -3);
        drive_sample(0, 1, 7);
        checks++;
        if (dv_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_block_early: got dv=%0b expected 0", dv_a);
        end
        drive_sample(1, 1, 2);
        checks++;
        if (dv_a !== 1'b1 || pix_a !== 21'sd7 || h_a !== 5'd0 || v_a !== 5'd0) begin
            failures++;
            $display("[TB] FAIL first_block: got dv=%0b pix=%0d h=%0d v=%0d expected dv=1 pix=7 h=0 v=0", dv_a, pix_a, h_a, v_a);
        end
        drive_idle();
        checks++;
        if (dv_a !== 1'b0 || pix_a !== 21'sd7) begin
            failures++;
            $display("[TB] FAIL first_block_hold: got dv=%0b pix=%0d expected dv=0 pix=7", dv_a, pix_a);
        end
    endtask

    task automatic test_relu();
        drive_sample(2, 0, -1);
        drive_sample(3, 0, -100);
        drive_sample(2, 1, -1048576);
        drive_sample(3, 1, -5);
        checks++;
        if (dv_a !== 1'b1 || pix_a !== 21'sd0 || h_a !== 5'd1 || v_a !== 5'd0) begin
            failures++;
            $display("[TB] FAIL relu_negative: got dv=%0b pix=%0d h=%0d expected dv=1 pix=0 h=1", dv_a, pix_a, h_a);
        end
        drive_sample(4, 0, -(int'($urandom_range(1000, 1))));
        drive_sample(5, 0, int'($urandom_range(1000, 0)));
        drive_sample(4, 1, 1048575);
        drive_sample(5, 1, int'($urandom_range(1048574, 0)));
        checks++;
        if (dv_a !== 1'b1 || pix_a !== 21'sd1048575 || h_a !== 5'd2) begin
            failures++;
            $display("[TB] FAIL relu_max: got dv=%0b pix=%0d h=%0d expected dv=1 pix=1048575 h=2", dv_a, pix_a, h_a);
        end
        drive_idle();
    endtask

    task automatic test_full_frame();
        fill_ramp();
        clear_queues();
        send_rows(26, 0, 25, 100);
        build_expected(26, 26);
        compare_stream(0, "full_frame");
        checks++;
        if (qa_pix.size() < 1 || qa_pix[0] !== 27) begin
            failures++;
            $display("[TB] FAIL full_frame_first: got %0d expected 27", (qa_pix.size() > 0) ? qa_pix[0] : -1);
        end
        checks++;
        if (qa_h.size() < 1 || qa_h[qa_h.size()-1] !== 12 || qa_v[qa_v.size()-1] !== 12) begin
            failures++;
            $display("[TB] FAIL full_frame_last: got h=%0d v=%0d expected h=12 v=12",
                     (qa_h.size() > 0) ? qa_h[qa_h.size()-1] : -1, (qa_v.size() > 0) ? qa_v[qa_v.size()-1] : -1);
        end
    endtask

    task automatic test_gappy();
        fill_ramp();
        clear_queues();
        send_rows(26, 0, 25, 40);
        build_expected(26, 26);
        compare_stream(0, "gappy_ramp");
        fill_random();
        clear_queues();
        send_rows(26, 0, 25, 40);
        build_expected(26, 26);
        compare_stream(0, "gappy_random");
    endtask

    task automatic test_odd_geometry();
        fill_random();
        clear_queues();
        send_rows(27, 0, 26, 70);
        build_expected(27, 27);
        compare_stream(1, "odd_27x27");
        build_expected(26, 26);
        compare_stream(0, "odd_stream_on_26x26");
    endtask

    task automatic test_reset_mid_frame();
        fill_random();
        clear_queues();
        send_rows(26, 0, 0, 100);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        send_rows(26, 1, 1, 100);
        checks++;
        if (qa_pix.size() !== 0 || qb_pix.size() !== 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_frame_odd_row: got %0d/%0d pulses expected 0", qa_pix.size(), qb_pix.size());
        end
        fill_random();
        clear_queues();
        send_rows(26, 0, 25, 100);
        build_expected(26, 26);
        compare_stream(0, "reset_mid_frame_restart");
    endtask

    initial begin
        rst_in        = 1'b0;
        data_valid_in = 1'b0;
        pixel_data_in = '0;
        hcount_in     = '0;
        vcount_in     = '0;
        #2;
        test_reset();
        test_relu();
        test_full_frame();
        test_gappy();
        test_odd_geometry();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
